// File: rtl/vmc_input_conditioner.sv
// Switch front-end for the vending FSM: synchronise, debounce, edge-detect, arbitrate,
// then hold each accepted command for one FSM slow-clock period. Also tracks a coin total.
module vmc_input_conditioner #(
  parameter int DEB_CYCLES  = 500000,
  parameter int HOLD_CYCLES = 16777216
) (
  input  logic       MAX10_CLK1_50,
  input  logic       nRESET,
  input  logic [6:0] sw_raw,
  output logic [6:0] cmd_out,
  output logic       busy,
  output logic       coin_reject,
  output logic       overflow,
  output logic [7:0] coin_total
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  localparam logic [6:0] EV_START  = 7'b0000001;
  localparam logic [6:0] EV_SELECT = 7'b0000010;
  localparam logic [6:0] EV_OK     = 7'b0000100;
  localparam logic [6:0] EV_CANCEL = 7'b0001000;
  localparam logic [6:0] COIN_MASK = 7'b1110000;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state;
  logic [6:0]      sync1, sync2, stable, stable_d;
  logic [DW-1:0]   deb_cnt [7];
  logic [HW-1:0]   hold_cnt;
  logic [6:0]      pend;

  logic [6:0]      edges, pick, pend_nxt, load_val;
  logic            coin_clash, ovf_nxt, hold_done;
  logic [8:0]      total_sum;

  function automatic logic [7:0] coin_value(input logic [6:0] ev);
    if (ev[4])      return 8'd1;
    else if (ev[5]) return 8'd5;
    else if (ev[6]) return 8'd10;
    else            return 8'd0;
  endfunction

  // Counter tracks consecutive clocks of disagreement; the flip happens on the clock it would reach DEB_CYCLES.
  always_ff @(negedge MAX10_CLK1_50 or negedge nRESET) begin
    if (!nRESET) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 7; i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= sw_raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < 7; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    edges      = stable & ~stable_d;
    coin_clash = ($countones(edges[6:4]) > 1);
    pick       = '0;
    if (edges[3])         pick = EV_CANCEL;
    else if (edges[2])    pick = EV_OK;
    else if (edges[1])    pick = EV_SELECT;
    else if (edges[0])    pick = EV_START;
    else if (!coin_clash) pick = edges & COIN_MASK;

    // An event on the final hold clock enters the slot first, so the reload sees it.
    pend_nxt = pend;
    ovf_nxt  = 1'b0;
    if (state == HOLD && pick != '0) begin
      if (pend == '0) begin
        pend_nxt = pick;
      end else begin
        ovf_nxt = 1'b1;
        if (pick[3] && !pend[3]) pend_nxt = pick;
      end
    end

    hold_done = (state == HOLD) && (hold_cnt == HOLD_LAST);
    if (state == IDLE)  load_val = pick;
    else if (hold_done) load_val = pend_nxt;
    else                load_val = '0;

    total_sum = {1'b0, coin_total} + {1'b0, coin_value(load_val)};
  end

  always_ff @(negedge MAX10_CLK1_50 or negedge nRESET) begin
    if (!nRESET) begin
      state       <= IDLE;
      cmd_out     <= '0;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
      overflow    <= 1'b0;
      coin_total  <= '0;
      pend        <= '0;
      hold_cnt    <= '0;
    end else begin
      coin_reject <= coin_clash;
      overflow    <= ovf_nxt;
      pend        <= pend_nxt;
      coin_total  <= total_sum[8] ? 8'hFF : total_sum[7:0];
      case (state)
        IDLE: begin
          if (pick != '0) begin
            cmd_out  <= pick;
            hold_cnt <= '0;
            busy     <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + HW'(1);
          if (hold_done) begin
            hold_cnt <= '0;
            if (pend_nxt != '0) begin
              cmd_out <= pend_nxt;
              pend    <= '0;
            end else begin
              cmd_out <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmc_input_conditioner.sv
// Self-checking bench: a window-based behavioural model is compared every clock,
// plus directed scenarios with literal expectations.
module tb_vmc_input_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic       clk;
  logic       nRESET;
  logic [6:0] sw_raw;
  logic [6:0] cmd_out;
  logic       busy, coin_reject, overflow;
  logic [7:0] coin_total;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 0;

  vmc_input_conditioner #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .MAX10_CLK1_50(clk),
    .nRESET(nRESET),
    .sw_raw(sw_raw),
    .cmd_out(cmd_out),
    .busy(busy),
    .coin_reject(coin_reject),
    .overflow(overflow),
    .coin_total(coin_total)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model state: raw sample history, debounced levels, countdown of the current hold.
  logic [6:0] m_hist [0:DEB+1];
  logic [6:0] m_stable, m_ev, m_cmd, m_pend;
  int         m_left, m_total;
  logic       m_reject, m_overflow;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_arbitrate(input logic [6:0] ev, output logic [6:0] kept,
                                          output logic rej);
    int ncoins;
    int order [4];
    order  = '{3, 2, 1, 0};
    ncoins = $countones(ev[6:4]);
    rej    = (ncoins >= 2);
    kept   = '0;
    foreach (order[k])
      if (kept == '0 && ev[order[k]]) kept[order[k]] = 1'b1;
    if (kept == '0 && ncoins == 1) kept = ev & 7'b1110000;
  endfunction

  function automatic int coin_val(input logic [6:0] x);
    int vals [3];
    int v;
    vals = '{1, 5, 10};
    v = 0;
    for (int b = 0; b < 3; b++) if (x[b+4]) v = vals[b];
    return v;
  endfunction

  task automatic model_load(input logic [6:0] x);
    m_cmd   = x;
    m_left  = HOLD;
    m_total = m_total + coin_val(x);
    if (m_total > 255) m_total = 255;
  endtask

  always @(negedge clk or negedge nRESET) begin
    logic [6:0] kept, nstable;
    logic       rej, flip;
    if (!nRESET) begin
      for (int j = 0; j <= DEB + 1; j++) m_hist[j] = '0;
      m_stable = '0; m_ev = '0; m_cmd = '0; m_pend = '0;
      m_left = 0; m_total = 0; m_reject = 0; m_overflow = 0;
    end else begin
      model_arbitrate(m_ev, kept, rej);
      m_reject   = rej;
      m_overflow = 0;
      if (m_left == 0) begin
        if (kept != '0) model_load(kept);
      end else begin
        if (kept != '0) begin
          if (m_pend == '0) m_pend = kept;
          else begin
            m_overflow = 1;
            if (kept == 7'b0001000 && m_pend != 7'b0001000) m_pend = kept;
          end
        end
        m_left--;
        if (m_left == 0) begin
          if (m_pend != '0) begin
            model_load(m_pend);
            m_pend = '0;
          end else m_cmd = '0;
        end
      end
      for (int j = DEB + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = sw_raw;
      for (int i = 0; i < 7; i++) begin
        flip = 1;
        for (int j = 2; j <= DEB + 1; j++) if (m_hist[j][i] == m_stable[i]) flip = 0;
        nstable[i] = flip ? ~m_stable[i] : m_stable[i];
      end
      m_ev     = nstable & ~m_stable;
      m_stable = nstable;
    end
  end

  always @(posedge clk) begin
    if (chk_en && nRESET) begin
      checkOutput("cmd_out", cmd_out, m_cmd);
      checkOutput("busy", busy, (m_left != 0));
      checkOutput("coin_reject", coin_reject, m_reject);
      checkOutput("overflow", overflow, m_overflow);
      checkOutput("coin_total", coin_total, m_total);
    end
  end

  task automatic applyStimulus(input logic [6:0] v);
    sw_raw = v;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    sw_raw = '0;
    nRESET = 0;
    repeat (2) @(posedge clk);
    #1 nRESET = 1;
  endtask

  initial begin
    int first, len, first2, len2, seen, cnt, cnt2;
    logic [6:0] v;
    sw_raw = '0;
    nRESET = 1;
    #2 nRESET = 0;
    #1;
    checkOutput("rst_cmd_out", cmd_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_coin_reject", coin_reject, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_coin_total", coin_total, 0);
    @(posedge clk);
    #1 nRESET = 1;
    chk_en = 1;

    $display("[TB] test1: single Php5 press");
    first = -1; len = 0;
    for (int c = 0; c < 24; c++) begin
      applyStimulus(c < 20 ? 7'b0100000 : 7'b0000000);
      if (cmd_out == 7'b0100000) begin
        if (first < 0) first = c + 1;
        len++;
      end
    end
    checkOutput("t1_first_cycle", first, 7);
    checkOutput("t1_hold_len", len, 8);
    checkOutput("t1_coin_total", coin_total, 5);

    $display("[TB] test2: Php1 glitch");
    doReset();
    seen = 0;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(c < 3 ? 7'b0010000 : 7'b0000000);
      if (cmd_out != 0) seen++;
    end
    checkOutput("t2_cmd_seen", seen, 0);
    checkOutput("t2_coin_total", coin_total, 0);

    $display("[TB] test3: simultaneous coins");
    doReset();
    seen = 0; cnt = 0;
    for (int c = 0; c < 24; c++) begin
      applyStimulus(c < 10 ? 7'b1010000 : 7'b0000000);
      if (cmd_out != 0) seen++;
      if (coin_reject) cnt++;
    end
    checkOutput("t3_reject_pulses", cnt, 1);
    checkOutput("t3_cmd_seen", seen, 0);
    checkOutput("t3_coin_total", coin_total, 0);

    $display("[TB] test4: OK, SELECT, START overlap");
    doReset();
    first = -1; len = 0; first2 = -1; len2 = 0; seen = 0; cnt = 0;
    for (int c = 0; c < 32; c++) begin
      v = '0;
      v[2] = (c <= 11);
      v[1] = (c >= 3 && c <= 14);
      v[0] = (c >= 5 && c <= 16);
      applyStimulus(v);
      if (cmd_out == 7'b0000100) begin if (first < 0) first = c + 1; len++; end
      if (cmd_out == 7'b0000010) begin if (first2 < 0) first2 = c + 1; len2++; end
      if (cmd_out == 7'b0000001) seen++;
      if (overflow) cnt++;
    end
    checkOutput("t4_ok_first", first, 7);
    checkOutput("t4_ok_len", len, 8);
    checkOutput("t4_sel_first", first2, 15);
    checkOutput("t4_sel_len", len2, 8);
    checkOutput("t4_overflow_pulses", cnt, 1);
    checkOutput("t4_start_seen", seen, 0);

    $display("[TB] test5: saturation and reset mid-hold");
    doReset();
    for (int p = 0; p < 26; p++)
      for (int c = 0; c < 12; c++) applyStimulus(c < 6 ? 7'b1000000 : 7'b0000000);
    checkOutput("t5_total_sat", coin_total, 255);
    cnt2 = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(c < 6 ? 7'b1000000 : 7'b0000000);
      if (coin_total != 255) cnt2++;
    end
    checkOutput("t5_no_wrap", cnt2, 0);
    for (int c = 0; c < 9; c++) applyStimulus(7'b0000001);
    checkOutput("t5_busy_before_rst", busy, 1);
    #2 nRESET = 0;
    #1;
    checkOutput("t5_rst_cmd_out", cmd_out, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_coin_total", coin_total, 0);
    checkOutput("t5_rst_overflow", overflow, 0);
    checkOutput("t5_rst_coin_reject", coin_reject, 0);
    sw_raw = '0;
    @(posedge clk);
    #1 nRESET = 1;

    $display("[TB] random phase");
    for (int c = 0; c < 4000; c++) begin
      int r;
      v = sw_raw;
      r = $urandom_range(0, 99);
      if (r < 10) v[$urandom_range(0, 6)] ^= 1'b1;
      else if (r < 12) v = 7'($urandom);
      applyStimulus(v);
    end
    repeat (20) applyStimulus(7'b0000000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
